network_tx_queued: RTL and testbench
====================================

Name: network_tx_queued

Overview:
- Next-generation tile network transmitter: decouples the core's valid-credit request interface from the network's valid-ready interface with a parametrised request queue.
- Enforces an outstanding-request credit limit and tracks idle/fence state.
- Demultiplexes returned responses to a parametrised number of response channels, with forced acceptance when the return FIFO is full.
- Sits between the vanilla core's remote-request stage and the tile's endpoint; NPA translation has already been done upstream.

Parameters:
- packet_width_p, 128, width of a fully formed outgoing manycore request packet.
- data_width_p, 32, response data width.
- reg_id_width_p, 5, response register-id width.
- req_fifo_els_p, 4, request queue depth (≥2); equal to the number of core-side credits after reset.
- max_out_credits_p, 32, maximum outstanding network requests.
- num_resp_ch_p, 3, response channels (ch0 = ifetch, always accepted; ch≥1 = load writeback channels).
- credit_width_lp, $clog2(max_out_credits_p+1), derived.
- resp_type_width_lp, `BSG_SAFE_CLOG2(num_resp_ch_p), derived.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_packet_i  in  packet_width_p  formed request packet.
- req_v_i  in  1  request valid; core only asserts while holding a credit.
- req_invalid_i  in  1  request carries an invalid EVA; qualified by req_v_i.
- req_credit_o  out  1  one-cycle pulse returning one queue credit to the core.
- out_packet_o  out  packet_width_p  head-of-queue packet.
- out_v_o  out  1  network valid.
- out_ready_i  in  1  network ready.
- out_credit_return_i  in  1  network returned one outstanding credit.
- out_credits_o  out  credit_width_lp  available network credits.
- out_idle_o  out  1  queue empty and all credits returned.
- invalid_eva_access_o  out  1  pulse when an invalid request is dropped.
- invalid_eva_sticky_o  out  1  set on any drop; cleared only by reset.
- returned_v_i  in  1  response valid.
- returned_data_i  in  data_width_p  response data.
- returned_reg_id_i  in  reg_id_width_p  destination register.
- returned_type_i  in  resp_type_width_lp  response channel index.
- returned_fifo_full_i  in  1  return FIFO full.
- returned_yumi_o  out  1  response consumed.
- resp_v_o  out  num_resp_ch_p  per-channel valid.
- resp_force_o  out  num_resp_ch_p  per-channel force.
- resp_data_o  out  data_width_p  broadcast response data.
- resp_rd_o  out  reg_id_width_p  broadcast destination register.
- resp_yumi_i  in  num_resp_ch_p  per-channel accept; bit 0 is ignored.

Behaviour:
- Reset:
  - queue empty; out_credits_o = max_out_credits_p.
  - req_credit_o = 0, out_v_o = 0, invalid_eva_access_o = 0, invalid_eva_sticky_o = 0, out_idle_o = 1.
  - Reset asserted mid-operation discards all queued entries and restores credits; the core re-initialises its credit count to req_fifo_els_p.
- Enqueue:
  - When req_v_i = 1, write {req_invalid_i, req_packet_i} to the tail.
  - No bypass: an entry enqueued in cycle t is visible at the head in cycle t+1 at the earliest.
  - Enqueue into a full queue is a protocol error: assertion fires and the entry is dropped.
- Head handling:
  - out_v_o = head_valid & ~head_invalid & (out_credits_o != 0). It does not depend on out_ready_i.
  - Send = out_v_o & out_ready_i; a send dequeues the head.
  - An invalid head dequeues unconditionally in the cycle it is at the head: out_v_o = 0, invalid_eva_access_o = 1 that cycle, invalid_eva_sticky_o set from the next cycle.
- Credit return to the core: req_credit_o is registered and pulses in cycle t+1 for every dequeue in cycle t, including drops. There is at most one dequeue per cycle.
- Network credit counter:
  - Decrements on send; increments on out_credit_return_i.
  - Both in the same cycle: counter unchanged.
  - Return while the counter equals max_out_credits_p: assertion fires and the counter saturates.
  - Counter at 0: the head stalls with out_v_o = 0.
- out_idle_o = queue empty & (out_credits_o == max_out_credits_p); combinational from state.
- Simultaneous enqueue and dequeue on a full queue: allowed, count unchanged. Pointers wrap modulo req_fifo_els_p, non-power-of-two depths included.
- Response demux (combinational, zero latency):
  - resp_data_o = returned_data_i; resp_rd_o = returned_reg_id_i.
  - Let c = returned_type_i. resp_v_o[c] = returned_v_i; all other bits are 0.
  - c = 0: returned_yumi_o = returned_v_i; resp_force_o = 0.
  - c ≥ 1: resp_force_o[c] = returned_fifo_full_i; returned_yumi_o = resp_yumi_i[c] | returned_fifo_full_i.
  - c ≥ num_resp_ch_p: assertion fires; the response is consumed with no channel valid.
  - returned_fifo_full_i = 1 without returned_yumi_o is an assertion failure.

Test Plan:
- Reset, then 4 valid requests on back-to-back cycles with out_ready_i = 1 → out_v_o first high at cycle 1; 4 sends; req_credit_o pulses at cycles 2–5; out_credits_o = 28.
- out_ready_i = 0 while 4 requests are enqueued → queue full, out_v_o held high with the head packet stable. A 5th req_v_i triggers the assertion. Raise out_ready_i → 4 sends in order.
- Invalid request between two valid ones → middle entry dropped, invalid_eva_access_o pulses once, sticky flag set, only 2 sends, 3 req_credit_o pulses.
- max_out_credits_p = 2: 3 requests → 2 sends, then out_v_o = 0 with the counter at 0. out_credit_return_i pulse → third send. Send and return in the same cycle → counter unchanged.
- Responses with type 0, 1, 2 and resp_yumi_i = 0 → type 0 consumed immediately; types 1 and 2 held until their yumi. With returned_fifo_full_i = 1 and type 2 → resp_force_o = 3'b100, returned_yumi_o = 1.
- Assert reset with 3 entries queued and out_credits_o = 20 → the next cycle shows an empty queue, out_credits_o = 32, out_idle_o = 1, sticky flag cleared.

Source files
------------

// File: rtl/network_tx_queued.sv
// Tile network transmitter: credit-limited request queue
// plus returned-response demux to per-channel writeback.
module network_tx_queued #(
  parameter int packet_width_p = 128,
  parameter int data_width_p = 32,
  parameter int reg_id_width_p = 5,
  parameter int req_fifo_els_p = 4,
  parameter int max_out_credits_p = 32,
  parameter int num_resp_ch_p = 3,
  localparam int credit_width_lp =
    $clog2(max_out_credits_p+1),
  localparam int resp_type_width_lp =
    (num_resp_ch_p > 1) ? $clog2(num_resp_ch_p) : 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [packet_width_p-1:0] req_packet_i,
  input  logic req_v_i,
  input  logic req_invalid_i,
  output logic req_credit_o,
  output logic [packet_width_p-1:0] out_packet_o,
  output logic out_v_o,
  input  logic out_ready_i,
  input  logic out_credit_return_i,
  output logic [credit_width_lp-1:0] out_credits_o,
  output logic out_idle_o,
  output logic invalid_eva_access_o,
  output logic invalid_eva_sticky_o,
  input  logic returned_v_i,
  input  logic [data_width_p-1:0] returned_data_i,
  input  logic [reg_id_width_p-1:0] returned_reg_id_i,
  input  logic [resp_type_width_lp-1:0] returned_type_i,
  input  logic returned_fifo_full_i,
  output logic returned_yumi_o,
  output logic [num_resp_ch_p-1:0] resp_v_o,
  output logic [num_resp_ch_p-1:0] resp_force_o,
  output logic [data_width_p-1:0] resp_data_o,
  output logic [reg_id_width_p-1:0] resp_rd_o,
  input  logic [num_resp_ch_p-1:0] resp_yumi_i
);

  localparam int ptr_w_lp =
    (req_fifo_els_p > 1) ? $clog2(req_fifo_els_p) : 1;
  localparam int cnt_w_lp = $clog2(req_fifo_els_p+1);
  localparam int entry_w_lp = packet_width_p + 1;

  localparam logic [ptr_w_lp-1:0] last_ptr_lp =
    ptr_w_lp'(req_fifo_els_p-1);
  localparam logic [cnt_w_lp-1:0] els_lp =
    cnt_w_lp'(req_fifo_els_p);
  localparam logic [credit_width_lp-1:0] max_cred_lp =
    credit_width_lp'(max_out_credits_p);

  logic [entry_w_lp-1:0] mem_q [req_fifo_els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic [credit_width_lp-1:0] cred_q, cred_d;
  logic req_credit_q, req_credit_d;
  logic sticky_q, sticky_d;

  logic head_v, head_inv, full, enq, deq, send;
  logic [entry_w_lp-1:0] head_entry;

  assign head_entry = mem_q[rptr_q];
  assign head_v = (cnt_q != '0);
  assign head_inv = head_entry[packet_width_p];
  assign full = (cnt_q == els_lp);

  // Head qualification, send/drop and enqueue decisions
  always_comb begin
    out_v_o = head_v & ~head_inv & (cred_q != '0);
    send = out_v_o & out_ready_i;
    deq = send | (head_v & head_inv);
    enq = req_v_i & (~full | deq);
    invalid_eva_access_o = head_v & head_inv;
    out_packet_o = head_entry[packet_width_p-1:0];
  end

  // Next-state for pointers, occupancy, credits and flags
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d = cnt_q;
    cred_d = cred_q;
    if (enq)
      wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
    if (deq)
      rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
    if (enq && !deq)
      cnt_d = cnt_q + 1'b1;
    else if (!enq && deq)
      cnt_d = cnt_q - 1'b1;
    if (send && !out_credit_return_i)
      cred_d = cred_q - 1'b1;
    else if (!send && out_credit_return_i
             && cred_q != max_cred_lp)
      cred_d = cred_q + 1'b1;
    req_credit_d = deq;
    sticky_d = sticky_q | invalid_eva_access_o;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      cred_q <= max_cred_lp;
      req_credit_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      cred_q <= cred_d;
      req_credit_q <= req_credit_d;
      sticky_q <= sticky_d;
    end
  end

  // Queue storage; contents are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (enq && !reset_i)
      mem_q[wptr_q] <= {req_invalid_i, req_packet_i};
  end

  assign req_credit_o = req_credit_q;
  assign out_credits_o = cred_q;
  assign invalid_eva_sticky_o = sticky_q;
  assign out_idle_o = (cnt_q == '0) & (cred_q == max_cred_lp);

  // Response demux; ifetch channel never back-pressures
  always_comb begin
    resp_v_o = '0;
    resp_force_o = '0;
    returned_yumi_o = returned_v_i;
    resp_data_o = returned_data_i;
    resp_rd_o = returned_reg_id_i;
    for (int i = 0; i < num_resp_ch_p; i++) begin
      if (returned_type_i == resp_type_width_lp'(i)) begin
        resp_v_o[i] = returned_v_i;
        if (i != 0) begin
          resp_force_o[i] = returned_fifo_full_i;
          returned_yumi_o =
            resp_yumi_i[i] | returned_fifo_full_i;
        end
      end
    end
  end

  // Protocol checks
  always @(posedge clk_i) begin
    if (!reset_i) begin
      a_enq_full: assert (!(req_v_i && full && !deq));
      a_cred_ovf: assert (!(out_credit_return_i && !send
                            && cred_q == max_cred_lp));
      a_bad_type: assert (!(returned_v_i &&
        int'(returned_type_i) >= num_resp_ch_p));
      a_full_yumi: assert (!(returned_fifo_full_i
                             && !returned_yumi_o));
    end
  end

endmodule

// File: tb/tb_network_tx_queued.sv
// Randomized bench for network_tx_queued against a
// queue-based reference model of the transmitter.
module tb_network_tx_queued;

  localparam int PW = 128;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int ELS = 4;
  localparam int MAXC = 32;
  localparam int NCH = 3;
  localparam int CW = $clog2(MAXC+1);
  localparam int TW = 2;

  logic clk = 1'b0;
  logic reset_i;
  logic [PW-1:0] req_packet_i;
  logic req_v_i, req_invalid_i, req_credit_o;
  logic [PW-1:0] out_packet_o;
  logic out_v_o, out_ready_i, out_credit_return_i;
  logic [CW-1:0] out_credits_o;
  logic out_idle_o, invalid_eva_access_o;
  logic invalid_eva_sticky_o;
  logic returned_v_i;
  logic [DW-1:0] returned_data_i;
  logic [RW-1:0] returned_reg_id_i;
  logic [TW-1:0] returned_type_i;
  logic returned_fifo_full_i, returned_yumi_o;
  logic [NCH-1:0] resp_v_o, resp_force_o, resp_yumi_i;
  logic [DW-1:0] resp_data_o;
  logic [RW-1:0] resp_rd_o;

  always #5 clk = ~clk;

  network_tx_queued dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .req_packet_i(req_packet_i),
    .req_v_i(req_v_i),
    .req_invalid_i(req_invalid_i),
    .req_credit_o(req_credit_o),
    .out_packet_o(out_packet_o),
    .out_v_o(out_v_o),
    .out_ready_i(out_ready_i),
    .out_credit_return_i(out_credit_return_i),
    .out_credits_o(out_credits_o),
    .out_idle_o(out_idle_o),
    .invalid_eva_access_o(invalid_eva_access_o),
    .invalid_eva_sticky_o(invalid_eva_sticky_o),
    .returned_v_i(returned_v_i),
    .returned_data_i(returned_data_i),
    .returned_reg_id_i(returned_reg_id_i),
    .returned_type_i(returned_type_i),
    .returned_fifo_full_i(returned_fifo_full_i),
    .returned_yumi_o(returned_yumi_o),
    .resp_v_o(resp_v_o),
    .resp_force_o(resp_force_o),
    .resp_data_o(resp_data_o),
    .resp_rd_o(resp_rd_o),
    .resp_yumi_i(resp_yumi_i)
  );

  typedef struct {
    logic inv;
    logic [PW-1:0] pkt;
  } ent_t;

  ent_t mq[$];
  int m_cred;
  int m_core_cred;
  logic m_sticky;
  logic m_credit_pulse;
  int n_tests = 0;
  int n_fail = 0;
  int n_sends = 0;
  int n_drops = 0;
  int n_zero_cred = 0;

  task automatic chk(input string tag,
                     input logic [PW-1:0] got,
                     input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cred = MAXC;
    m_core_cred = ELS;
    m_sticky = 1'b0;
    m_credit_pulse = 1'b0;
  endtask

  task automatic idle_inputs();
    req_v_i = 1'b0;
    req_invalid_i = 1'b0;
    req_packet_i = '0;
    out_ready_i = 1'b0;
    out_credit_return_i = 1'b0;
    returned_v_i = 1'b0;
    returned_data_i = '0;
    returned_reg_id_i = '0;
    returned_type_i = '0;
    returned_fifo_full_i = 1'b0;
    resp_yumi_i = '0;
  endtask

  // one cycle: drive at negedge, check, advance model at posedge
  task automatic cycle(input int p_req, input int p_inv,
                       input int p_rdy, input int p_ret,
                       input bit do_rst);
    logic e_v, e_inv_pulse, e_idle, send, deq;
    logic [NCH-1:0] e_rv, e_force;
    logic e_yumi;
    int t;
    @(negedge clk);
    idle_inputs();
    reset_i = do_rst;
    if (!do_rst) begin
      req_v_i = (m_core_cred > 0) &&
                ($urandom_range(99) < p_req);
      req_invalid_i = req_v_i && ($urandom_range(99) < p_inv);
      req_packet_i = {$urandom, $urandom, $urandom, $urandom};
      out_ready_i = ($urandom_range(99) < p_rdy);
      out_credit_return_i = (m_cred < MAXC) &&
                            ($urandom_range(99) < p_ret);
    end
    returned_v_i = $urandom_range(1);
    returned_type_i = TW'($urandom_range(NCH-1));
    returned_data_i = $urandom;
    returned_reg_id_i = RW'($urandom);
    resp_yumi_i = NCH'($urandom);
    returned_fifo_full_i = returned_v_i &&
                           ($urandom_range(3) == 0);
    #1;
    e_v = (mq.size() > 0) && !mq[0].inv && (m_cred != 0);
    e_inv_pulse = (mq.size() > 0) && mq[0].inv;
    e_idle = (mq.size() == 0) && (m_cred == MAXC);
    t = int'(returned_type_i);
    e_rv = '0;
    e_force = '0;
    e_rv[t] = returned_v_i;
    if (t == 0) begin
      e_yumi = returned_v_i;
    end else begin
      e_force[t] = returned_fifo_full_i;
      e_yumi = resp_yumi_i[t] | returned_fifo_full_i;
    end
    if (!do_rst) begin
      chk("out_v", PW'(out_v_o), PW'(e_v));
      if (e_v) chk("out_pkt", out_packet_o, mq[0].pkt);
      chk("credits", PW'(out_credits_o), PW'(m_cred));
      chk("idle", PW'(out_idle_o), PW'(e_idle));
      chk("inv_pulse", PW'(invalid_eva_access_o),
          PW'(e_inv_pulse));
      chk("sticky", PW'(invalid_eva_sticky_o),
          PW'(m_sticky));
      chk("req_credit", PW'(req_credit_o),
          PW'(m_credit_pulse));
    end
    chk("resp_v", PW'(resp_v_o), PW'(e_rv));
    chk("resp_force", PW'(resp_force_o), PW'(e_force));
    chk("ret_yumi", PW'(returned_yumi_o), PW'(e_yumi));
    chk("resp_data", PW'(resp_data_o), PW'(returned_data_i));
    chk("resp_rd", PW'(resp_rd_o), PW'(returned_reg_id_i));
    @(posedge clk);
    if (do_rst) begin
      model_reset();
    end else begin
      if (m_cred == 0 && mq.size() > 0) n_zero_cred++;
      send = e_v && out_ready_i;
      deq = send || e_inv_pulse;
      if (send) n_sends++;
      if (e_inv_pulse) n_drops++;
      if (m_credit_pulse) m_core_cred++;
      if (deq) void'(mq.pop_front());
      if (req_v_i) begin
        mq.push_back('{inv: req_invalid_i, pkt: req_packet_i});
        m_core_cred--;
      end
      m_cred = m_cred - int'(send) + int'(out_credit_return_i);
      m_sticky = m_sticky | e_inv_pulse;
      m_credit_pulse = deq;
    end
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    idle_inputs();
    reset_i = 1'b0;
    #1;
    chk({tag, "_idle"}, PW'(out_idle_o), PW'(1'b1));
    chk({tag, "_cred"}, PW'(out_credits_o), PW'(MAXC));
    chk({tag, "_sticky"}, PW'(invalid_eva_sticky_o), '0);
    chk({tag, "_outv"}, PW'(out_v_o), '0);
    chk({tag, "_rcred"}, PW'(req_credit_o), '0);
    chk({tag, "_inv"}, PW'(invalid_eva_access_o), '0);
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    check_reset_state("rst0");
    for (int i = 0; i < 200; i++) cycle(60, 15, 70, 40, 1'b0);
    for (int i = 0; i < 200; i++) cycle(70, 5, 90, 5, 1'b0);
    for (int i = 0; i < 40; i++) cycle(90, 0, 0, 30, 1'b0);
    cycle(0, 0, 0, 0, 1'b1);
    check_reset_state("rst1");
    for (int i = 0; i < 400; i++) cycle(50, 10, 60, 30, 1'b0);
    chk("saw_sends", PW'(n_sends > 50), PW'(1'b1));
    chk("saw_drops", PW'(n_drops > 0), PW'(1'b1));
    chk("saw_zero_cred", PW'(n_zero_cred > 0), PW'(1'b1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
